// File: rtl/pc_sequencer_if.sv
// Fetch/branch/handshake bundle between the PC sequencer and the core or testbench.
// The slave side is the sequencer; the master side supplies decode flags and the target lookup.
interface pc_sequencer_if #(
  parameter int D  = 10,
  parameter int CW = 8
);
  logic          start;
  logic          halt;
  logic          stall;
  logic          branch_en;
  logic          branch_taken;
  logic          branch_rel;
  logic [3:0]    branch_idx;
  logic [3:0]    lut_addr;
  logic [D-1:0]  lut_target;
  logic [D-1:0]  prog_ctr;
  logic          fetch_valid;
  logic          done;
  logic [CW-1:0] br_count;

  modport slave (
    input  start, halt, stall, branch_en, branch_taken, branch_rel, branch_idx, lut_target,
    output lut_addr, prog_ctr, fetch_valid, done, br_count
  );

  modport master (
    output start, halt, stall, branch_en, branch_taken, branch_rel, branch_idx, lut_target,
    input  lut_addr, prog_ctr, fetch_valid, done, br_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/FLUSH/DONE control, absolute or PC-relative
// branch resolution through a combinational lookup, and a saturating taken-branch count.
module pc_sequencer #(
  parameter int D  = 10,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [D-1:0]  PC_ZERO  = {D{1'b0}};
  localparam logic [D-1:0]  PC_ONE   = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state, next-PC and branch-count computation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = PC_ZERO;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (bus.halt) begin
          state_d = ST_DONE;
        end else if (bus.branch_en && bus.branch_taken) begin
          // Relative targets rely on modular addition for negative offsets.
          state_d = ST_FLUSH;
          if (bus.branch_rel) begin
            pc_d = pc_q + bus.lut_target;
          end else begin
            pc_d = bus.lut_target;
          end
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = PC_ZERO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, PC and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_ZERO;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.lut_addr    = bus.branch_idx;
  assign bus.prog_ctr    = pc_q;
  assign bus.fetch_valid = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.br_count    = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (D=10, CW=2) with a bench-side branch-target table.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  logic [9:0] lut_mem [16];
  int n_vec;
  int n_err;

  pc_sequencer_if #(.D(10), .CW(2)) bus ();

  pc_sequencer #(.D(10), .CW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.lut_target = lut_mem[bus.lut_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input int fv, input int dn, input int bc);
    chk({tag, ".pc"}, int'(bus.prog_ctr), pc);
    chk({tag, ".fv"}, int'(bus.fetch_valid), fv);
    chk({tag, ".done"}, int'(bus.done), dn);
    chk({tag, ".brc"}, int'(bus.br_count), bc);
  endtask

  task automatic set_br(input logic en, input logic taken, input logic rel, input logic [3:0] idx);
    bus.branch_en    = en;
    bus.branch_taken = taken;
    bus.branch_rel   = rel;
    bus.branch_idx   = idx;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) lut_mem[i] = 10'd0;
    lut_mem[1] = 10'd4;
    lut_mem[2] = 10'h3FF;
    lut_mem[3] = 10'd110;
    lut_mem[4] = 10'd1020;
    lut_mem[5] = 10'd20;
    lut_mem[6] = 10'd1023;
    lut_mem[7] = 10'd7;
    lut_mem[8] = 10'd9;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    bus.stall = 1'b0;
    set_br(1'b0, 1'b0, 1'b0, 4'd0);

    // Reset then start, free run
    step(); chk_all("rst0", 0, 0, 0, 0);
    step(); chk_all("rst1", 0, 0, 0, 0);
    reset = 1'b0;
    bus.start = 1'b1;
    step(); chk_all("start", 0, 1, 0, 0);
    bus.start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(); chk_all("run", i, 1, 0, 0);
    end

    // Absolute branch at PC 5 to 110
    set_br(1'b1, 1'b1, 1'b0, 4'd3);
    #1 chk("lut_addr", int'(bus.lut_addr), 3);
    step(); chk_all("abs_flush", 110, 0, 0, 1);
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("abs_run0", 110, 1, 0, 1);
    step(); chk_all("abs_run1", 111, 1, 0, 1);

    // Go to 4, then relative -1
    set_br(1'b1, 1'b1, 1'b0, 4'd1);
    step(); chk_all("to4", 4, 0, 0, 2);
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("at4", 4, 1, 0, 2);
    set_br(1'b1, 1'b1, 1'b1, 4'd2);
    step(); chk_all("rel_m1", 3, 0, 0, 3);
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("at3", 3, 1, 0, 3);

    // 1020 + 20 wraps to 16
    set_br(1'b1, 1'b1, 1'b0, 4'd4);
    step(); chk_all("to1020", 1020, 0, 0, 3);
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("at1020", 1020, 1, 0, 3);
    set_br(1'b1, 1'b1, 1'b1, 4'd5);
    step(); chk_all("rel_p20", 16, 0, 0, 3);
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("at16", 16, 1, 0, 3);

    // 1023 + 1 wraps to 0
    set_br(1'b1, 1'b1, 1'b0, 4'd6);
    step(); chk_all("to1023", 1023, 0, 0, 3);
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("at1023", 1023, 1, 0, 3);
    step(); chk_all("wrap", 0, 1, 0, 3);

    // Reset mid-run in RUN, restart to clear the count
    reset = 1'b1;
    step(); chk_all("rst_run", 0, 0, 0, 0);
    reset = 1'b0;
    bus.start = 1'b1;
    step(); chk_all("restart", 0, 1, 0, 0);
    bus.start = 1'b0;

    // Not-taken branch and stall
    set_br(1'b1, 1'b1, 1'b0, 4'd7);
    step(); chk_all("to7", 7, 0, 0, 1);
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("at7", 7, 1, 0, 1);
    set_br(1'b1, 1'b0, 1'b0, 4'd3);
    step(); chk_all("not_taken", 8, 1, 0, 1);
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stall", 8, 1, 0, 1);
    end
    set_br(1'b1, 1'b1, 1'b0, 4'd8);
    step(); chk_all("stall_br", 9, 0, 0, 2);
    bus.stall = 1'b0;
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("at9", 9, 1, 0, 2);

    // Halt wins over a taken branch
    bus.halt = 1'b1;
    bus.stall = 1'b1;
    set_br(1'b1, 1'b1, 1'b0, 4'd3);
    step(); chk_all("halt", 9, 0, 1, 2);
    bus.halt = 1'b0;
    bus.stall = 1'b0;
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("done_hold", 9, 0, 1, 2);
    bus.start = 1'b1;
    step(); chk_all("done_start", 0, 1, 0, 0);
    bus.start = 1'b0;

    // Halt during FLUSH is ignored
    set_br(1'b1, 1'b1, 1'b0, 4'd7);
    step(); chk_all("fl_br", 7, 0, 0, 1);
    set_br(1'b0, 1'b0, 1'b0, 4'd0);
    bus.halt = 1'b1;
    step(); chk_all("fl_halt", 7, 1, 0, 1);
    step(); chk_all("halt2", 7, 0, 1, 1);
    bus.halt = 1'b0;
    bus.start = 1'b1;
    step(); chk_all("restart2", 0, 1, 0, 0);
    bus.start = 1'b0;

    // Saturation with CW=2, reset asserted in FLUSH
    for (int i = 1; i <= 5; i++) begin
      set_br(1'b1, 1'b1, 1'b0, 4'd7);
      step(); chk_all("sat", 7, 0, 0, (i > 3) ? 3 : i);
      set_br(1'b0, 1'b0, 1'b0, 4'd0);
      if (i < 5) begin
        step(); chk_all("sat_run", 7, 1, 0, (i > 3) ? 3 : i);
      end
    end
    reset = 1'b1;
    step(); chk_all("rst_flush", 0, 0, 0, 0);
    reset = 1'b0;
    step(); chk_all("idle_hold", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
